entropy_fifo_err_collector: RTL and testbench
=============================================

// Module: entropy_fifo_err_collector
// PURPOSE
//  Multi-channel FIFO exception collector for entropy complex IPs (entropy_src, CSRNG, EDN).
//  Detects read/write/state errors on NumFifos FIFOs and produces registered, edge-detected pulses.
//  Keeps sticky status, saturating per-FIFO error counters and a first-error capture.
//  Drives a single alert through an ack handshake; sits beside the FIFOs and feeds the IP's alert/CSR logic.
// PARAMETERS
//  NumFifos   4  number of monitored FIFOs (>=1)
//  PackerMask 0  NumFifos-bit; bit i=1 -> FIFO i is a packer FIFO (only write errors, via !wready)
//  CntWidth   8  per-FIFO error counter width (>=2)
//  localparam IdxW = (NumFifos>1) ? $clog2(NumFifos) : 1
// PORTS
//  clk_i        in   1             clock
//  rst_ni       in   1             reset, synchronous, active-low
//  wvalid_i     in   NumFifos      write request per FIFO
//  wready_i     in   NumFifos      write ready per FIFO (packer FIFOs)
//  rvalid_i     in   NumFifos      read data valid per FIFO
//  rready_i     in   NumFifos      read request per FIFO
//  full_i       in   NumFifos      FIFO full per FIFO
//  clr_i        in   1             clear sticky bits, counters, first-error capture
//  alert_ack_i  in   1             alert acknowledge (level)
//  err_pulse_o  out  3*NumFifos    [3*i+t] one-cycle error pulse; t: 0=read 1=write 2=state
//  err_sticky_o out  3*NumFifos    sticky version of err_pulse_o
//  err_cnt_o    out  CntWidth*NumFifos  [CntWidth*i +: CntWidth] saturating error count, FIFO i
//  first_vld_o  out  1             first-error capture valid
//  first_fifo_o out  IdxW          FIFO index of first error
//  first_type_o out  2             type of first error (0/1/2 as above)
//  alert_o      out  1             error alert, held until acknowledged
// BEHAVIOUR
//  Reset: all outputs 0; edge-history flops 0; FSM in IDLE; pending flag 0.
//  Conditions per FIFO i (combinational on inputs):
//   write: wvalid_i & (PackerMask[i] ? !wready_i : full_i)
//   read:  PackerMask[i] ? 0 : (rready_i & !rvalid_i)
//   state: PackerMask[i] ? 0 : (full_i & !rvalid_i)
//  Edge detect: hist <= cond every cycle; new = cond & !hist.
//  err_pulse_o <= new (registered): condition rising at edge k -> pulse high in cycle after edge k.
//   Exactly one pulse per rising edge; a held condition gives one pulse.
//  Sticky: set by new, cleared by clr_i; set wins over clr_i in the same cycle.
//  Counter i: cnt <= (clr_i ? 0 : cnt) + popcount(new[3i+:3]), saturating at 2^CntWidth-1.
//   Same-cycle clr_i + new: counter loads the increment only.
//  First capture: when !first_vld_o (or clr_i) and any new bit, latch lowest FIFO index.
//   Within that FIFO, latch lowest type; set first_vld_o. Later errors do not overwrite.
//   clr_i with no new bit -> first_vld_o=0, fifo/type=0.
//  Alert FSM (any_new = |new):
//   IDLE:    any_new -> ALERT
//   ALERT:   alert_o=1; alert_ack_i -> HOLDOFF
//   HOLDOFF: alert_o=0; waits for !alert_ack_i, then -> ALERT if pending|any_new, else IDLE;
//            pending cleared on leaving.
//   pending: set by any_new while in ALERT or HOLDOFF.
//   alert_o is registered: first rising error at edge k -> alert_o high after edge k+1.
//   Ack held high across HOLDOFF does not re-trigger.
//  Reset mid-operation (rst_ni low at an edge): synchronous return to reset values; inputs during reset ignored.
//  clr_i does not affect the FSM or the edge history.
// TESTING
//  1 Non-packer FIFO0: rready=1, rvalid=0 for 5 cycles -> err_pulse_o[0] high 1 cycle; sticky[0]=1; cnt0=1; first=(0,0).
//  2 Packer FIFO2 (PackerMask=4'b0100): wvalid=1, wready=0, rready=1, rvalid=0 -> only bit 7 (write) pulses; no read/state pulses.
//  3 FIFO1 write and FIFO3 state rise in the same cycle -> first=(1,1); cnt1=1, cnt3=1.
//     Then FIFO1 full&!rvalid&rready rise together -> cnt1=3.
//  4 CntWidth=2: 5 separate read-error edges on FIFO0 -> cnt0 sticks at 3.
//     clr_i in the same cycle as a new pulse -> cnt0=1, sticky kept.
//  5 Alert: error -> alert_o=1; ack -> alert_o=0.
//     New error while ack high -> after ack drops, alert_o=1 again; no error -> IDLE.
//  6 rst_ni low for 1 cycle while alert_o=1, sticky set and cnt=3 -> all outputs 0 next cycle.
//     A still-held condition re-pulses once after reset.

Source files
------------

// File: rtl/entropy_fifo_err_collector.sv
// -----------------------------------------------------------------------------
// entropy_fifo_err_collector
//
// Collects FIFO exceptions for the entropy complex (entropy_src, CSRNG, EDN).
// Each of NumFifos FIFOs is watched for read, write and state errors. Every
// rising edge of an error condition produces one registered pulse. The pulses
// feed sticky status bits, saturating per-FIFO counters and a first-error
// capture. They also drive a single alert that is held until it is acknowledged.
//
// Ports
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   wvalid_i      write request per FIFO
//   wready_i      write ready per FIFO (used by packer FIFOs only)
//   rvalid_i      read data valid per FIFO
//   rready_i      read request per FIFO
//   full_i        FIFO full per FIFO
//   clr_i         clears sticky bits, counters and first-error capture
//   alert_ack_i   alert acknowledge (level)
//   err_pulse_o   [3*i+t] one-cycle error pulse; t: 0=read 1=write 2=state
//   err_sticky_o  sticky copy of err_pulse_o
//   err_cnt_o     [CntWidth*i +: CntWidth] saturating error count of FIFO i
//   first_vld_o   first-error capture valid
//   first_fifo_o  FIFO index of the first error
//   first_type_o  type of the first error (0/1/2 as above)
//   alert_o       error alert, held until acknowledged
// -----------------------------------------------------------------------------
module entropy_fifo_err_collector #(
  parameter int                  NumFifos   = 4,
  parameter logic [NumFifos-1:0] PackerMask = '0,
  parameter int                  CntWidth   = 8,
  localparam int                 IdxW       = (NumFifos > 1) ? $clog2(NumFifos) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NumFifos-1:0]          wvalid_i,
  input  logic [NumFifos-1:0]          wready_i,
  input  logic [NumFifos-1:0]          rvalid_i,
  input  logic [NumFifos-1:0]          rready_i,
  input  logic [NumFifos-1:0]          full_i,
  input  logic                         clr_i,
  input  logic                         alert_ack_i,
  output logic [3*NumFifos-1:0]        err_pulse_o,
  output logic [3*NumFifos-1:0]        err_sticky_o,
  output logic [CntWidth*NumFifos-1:0] err_cnt_o,
  output logic                         first_vld_o,
  output logic [IdxW-1:0]              first_fifo_o,
  output logic [1:0]                   first_type_o,
  output logic                         alert_o
);

  localparam int NumErr = 3 * NumFifos;
  // Two spare bits hold the count plus up to three new errors without wrapping.
  localparam int SumW = CntWidth + 2;
  localparam logic [SumW-1:0] CntMax = SumW'({CntWidth{1'b1}});

  typedef enum logic [1:0] {
    StIdle,
    StAlert,
    StHoldoff
  } alert_state_e;

  logic [NumErr-1:0]   cond;
  logic [NumErr-1:0]   hist_q;
  logic [NumErr-1:0]   new_err;
  logic                any_new;

  logic [CntWidth-1:0] cnt_q [NumFifos];
  logic [CntWidth-1:0] cnt_d [NumFifos];
  logic [SumW-1:0]     cnt_sum [NumFifos];

  logic                hit;
  logic [IdxW-1:0]     hit_fifo;
  logic [1:0]          hit_type;

  alert_state_e        state_q, state_d;
  logic                pending_q, pending_d;
  logic                alert_d;

  // ---------------------------------------------------------------------------
  // Error conditions. A packer FIFO can only report a write error, when a
  // write is refused. Every other FIFO reports reads from an empty FIFO,
  // writes into a full FIFO, and a full FIFO that shows no valid data.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    cond = '0;
    for (int i = 0; i < NumFifos; i++) begin
      if (PackerMask[i]) begin
        cond[3*i+1] = wvalid_i[i] & ~wready_i[i];
      end else begin
        cond[3*i+0] = rready_i[i] & ~rvalid_i[i];
        cond[3*i+1] = wvalid_i[i] & full_i[i];
        cond[3*i+2] = full_i[i] & ~rvalid_i[i];
      end
    end
  end

  // Rising-edge detect: a condition that is held produces only one event.
  assign new_err = cond & ~hist_q;
  assign any_new = |new_err;

  // ---------------------------------------------------------------------------
  // Counter next state: clr_i drops the old count but keeps this cycle's
  // increment, and the result saturates at all-ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      cnt_sum[i] = (clr_i ? '0 : SumW'(cnt_q[i]))
                 + SumW'(new_err[3*i+0])
                 + SumW'(new_err[3*i+1])
                 + SumW'(new_err[3*i+2]);
      cnt_d[i]   = (cnt_sum[i] > CntMax) ? CntMax[CntWidth-1:0]
                                         : cnt_sum[i][CntWidth-1:0];
    end
  end

  always_comb begin
    err_cnt_o = '0;
    for (int i = 0; i < NumFifos; i++) begin
      err_cnt_o[CntWidth*i +: CntWidth] = cnt_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // First-error selection. The scan runs downward so that the last match is
  // the lowest FIFO index. Within that FIFO the lowest error type wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    hit      = 1'b0;
    hit_fifo = '0;
    hit_type = 2'd0;
    for (int i = NumFifos - 1; i >= 0; i--) begin
      if (|new_err[3*i +: 3]) begin
        hit      = 1'b1;
        hit_fifo = IdxW'(i);
        hit_type = new_err[3*i+0] ? 2'd0 :
                   new_err[3*i+1] ? 2'd1 : 2'd2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alert FSM. An error that arrives while an alert is outstanding or being
  // acknowledged is remembered in pending_q. It re-raises the alert once the
  // acknowledge is released, so a long acknowledge never hides an error.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      StIdle: begin
        if (any_new) state_d = StAlert;
      end
      StAlert: begin
        if (any_new)     pending_d = 1'b1;
        if (alert_ack_i) state_d   = StHoldoff;
      end
      StHoldoff: begin
        if (!alert_ack_i) begin
          state_d   = (pending_q || any_new) ? StAlert : StIdle;
          pending_d = 1'b0;
        end else if (any_new) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // alert_o follows the state register one cycle later.
    alert_d = (state_q == StAlert);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample pre-edge values no matter how the blocks are ordered.
    if (!rst_ni) begin
      hist_q       <= '0;
      err_pulse_o  <= '0;
      err_sticky_o <= '0;
      first_vld_o  <= 1'b0;
      first_fifo_o <= '0;
      first_type_o <= 2'd0;
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      alert_o      <= 1'b0;
    end else begin
      hist_q       <= cond;
      err_pulse_o  <= new_err;
      // A new error wins over a same-cycle clear.
      err_sticky_o <= (clr_i ? '0 : err_sticky_o) | new_err;
      if ((clr_i || !first_vld_o) && hit) begin
        first_vld_o  <= 1'b1;
        first_fifo_o <= hit_fifo;
        first_type_o <= hit_type;
      end else if (clr_i) begin
        first_vld_o  <= 1'b0;
        first_fifo_o <= '0;
        first_type_o <= 2'd0;
      end
      state_q      <= state_d;
      pending_q    <= pending_d;
      alert_o      <= alert_d;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the counter array is reset explicitly. The counts are visible
    // outputs and must read zero after reset, so this is not a RAM.
    if (!rst_ni) begin
      for (int i = 0; i < NumFifos; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumFifos; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_entropy_fifo_err_collector.sv
// -----------------------------------------------------------------------------
// Testbench for entropy_fifo_err_collector (4 FIFOs, FIFO2 is a packer FIFO,
// 2-bit counters). A behavioural model tracks each error condition, edge,
// counter, capture and alert step. The model is compared with the DUT on every
// falling edge. Directed scenarios add literal expectations; randomized traffic
// with occasional clear/ack/reset follows.
// -----------------------------------------------------------------------------
module tb_entropy_fifo_err_collector;

  localparam int              NF   = 4;
  localparam int              CW   = 2;
  localparam logic [NF-1:0]   PM   = 4'b0100;
  localparam int              NE   = 3 * NF;
  localparam int              CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NF-1:0]   wvalid, wready, rvalid, rready, full;
  logic            clr, ack;
  logic [NE-1:0]   err_pulse, err_sticky;
  logic [CW*NF-1:0] err_cnt;
  logic            first_vld;
  logic [1:0]      first_fifo;
  logic [1:0]      first_type;
  logic            alert;

  entropy_fifo_err_collector #(
    .NumFifos  (NF),
    .PackerMask(PM),
    .CntWidth  (CW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wvalid_i    (wvalid),
    .wready_i    (wready),
    .rvalid_i    (rvalid),
    .rready_i    (rready),
    .full_i      (full),
    .clr_i       (clr),
    .alert_ack_i (ack),
    .err_pulse_o (err_pulse),
    .err_sticky_o(err_sticky),
    .err_cnt_o   (err_cnt),
    .first_vld_o (first_vld),
    .first_fifo_o(first_fifo),
    .first_type_o(first_type),
    .alert_o     (alert)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_ALERT = 1, M_HOLD = 2;

  bit m_hist[NE], m_pulse[NE], m_sticky[NE];
  int m_cnt[NF];
  bit m_first_vld;
  int m_first_fifo, m_first_type;
  int m_fsm;
  bit m_pending, m_alert;
  bit model_ready = 0;

  function automatic bit m_cond(input int f, input int t);
    bit pk;
    pk = PM[f];
    case (t)
      0:       return pk ? 1'b0 : (rready[f] && !rvalid[f]);
      1:       return wvalid[f] && (pk ? !wready[f] : full[f]);
      default: return pk ? 1'b0 : (full[f] && !rvalid[f]);
    endcase
  endfunction

  always @(posedge clk) begin
    bit c[NE];
    bit nw[NE];
    bit any;
    int pop, base;
    if (!rst_n) begin
      for (int k = 0; k < NE; k++) begin
        m_hist[k] = 0; m_pulse[k] = 0; m_sticky[k] = 0;
      end
      for (int i = 0; i < NF; i++) m_cnt[i] = 0;
      m_first_vld = 0; m_first_fifo = 0; m_first_type = 0;
      m_fsm = M_IDLE; m_pending = 0; m_alert = 0;
    end else begin
      any = 0;
      for (int k = 0; k < NE; k++) begin
        c[k]  = m_cond(k / 3, k % 3);
        nw[k] = c[k] && !m_hist[k];
        any   = any || nw[k];
      end
      for (int k = 0; k < NE; k++) begin
        m_pulse[k]  = nw[k];
        m_sticky[k] = (clr ? 1'b0 : m_sticky[k]) | nw[k];
        m_hist[k]   = c[k];
      end
      for (int i = 0; i < NF; i++) begin
        pop  = int'(nw[3*i]) + int'(nw[3*i+1]) + int'(nw[3*i+2]);
        base = clr ? 0 : m_cnt[i];
        m_cnt[i] = (base + pop > CMAX) ? CMAX : base + pop;
      end
      if ((clr || !m_first_vld) && any) begin
        m_first_vld = 1;
        for (int k = NE - 1; k >= 0; k--) begin
          if (nw[k]) begin
            m_first_fifo = k / 3;
            m_first_type = k % 3;
          end
        end
      end else if (clr) begin
        m_first_vld = 0; m_first_fifo = 0; m_first_type = 0;
      end
      m_alert = (m_fsm == M_ALERT);
      case (m_fsm)
        M_IDLE:  if (any) m_fsm = M_ALERT;
        M_ALERT: begin
          if (any) m_pending = 1;
          if (ack) m_fsm = M_HOLD;
        end
        default: begin
          if (!ack) begin
            m_fsm = (m_pending || any) ? M_ALERT : M_IDLE;
            m_pending = 0;
          end else if (any) begin
            m_pending = 1;
          end
        end
      endcase
    end
    model_ready = 1;
  end

  // Compare process: DUT outputs are sampled on the falling edge.
  always @(negedge clk) begin
    logic [NE-1:0]    ep, es;
    logic [CW*NF-1:0] ec;
    if (model_ready) begin
      for (int k = 0; k < NE; k++) begin
        ep[k] = m_pulse[k];
        es[k] = m_sticky[k];
      end
      for (int i = 0; i < NF; i++) ec[CW*i +: CW] = CW'(m_cnt[i]);
      check("model_pulse",  err_pulse,  ep);
      check("model_sticky", err_sticky, es);
      check("model_cnt",    err_cnt,    ec);
      check("model_first",  {first_vld, first_fifo, first_type},
            {m_first_vld, 2'(m_first_fifo), 2'(m_first_type)});
      check("model_alert",  alert,      m_alert);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    wvalid = '0; wready = '1; rvalid = '0; rready = '0; full = '0; clr = 1'b0;
  endtask

  task automatic drain_alert();
    for (int r = 0; r < 3; r++) begin
      ack = 1'b1; step(3);
      ack = 1'b0; step(3);
    end
  endtask

  task automatic clear_all();
    clr = 1'b1; step(1); clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ack = 1'b0;
    idle_inputs();
    step(2);
    check("reset_pulse", err_pulse, 12'h000);
    check("reset_cnt",   err_cnt,   8'h00);
    check("reset_first", first_vld, 1'b0);
    check("reset_alert", alert,     1'b0);
    rst_n = 1'b1;
    step(1);

    // 1: FIFO0 read from empty, held for 5 cycles -> one pulse.
    rready[0] = 1'b1;
    step(1);
    check("s1_pulse",     err_pulse, 12'h001);
    step(1);
    check("s1_pulse_end", err_pulse, 12'h000);
    step(3);
    rready[0] = 1'b0;
    check("s1_sticky", err_sticky,    12'h001);
    check("s1_cnt0",   err_cnt[1:0],  2'd1);
    check("s1_first",  {first_vld, first_fifo, first_type}, 5'b1_00_00);
    drain_alert();
    clear_all();
    step(1);
    check("clr_sticky", err_sticky, 12'h000);

    // 2: packer FIFO2 only reports the refused write.
    wvalid[2] = 1'b1; wready[2] = 1'b0; rready[2] = 1'b1; full[2] = 1'b1;
    step(1);
    check("s2_pulse", err_pulse, 12'h080);
    idle_inputs();
    step(1);
    check("s2_sticky", err_sticky, 12'h080);
    drain_alert();
    clear_all();

    // 3: FIFO1 write and FIFO3 state errors rise together.
    wvalid[1] = 1'b1; full[1] = 1'b1; rvalid[1] = 1'b1; full[3] = 1'b1;
    step(1);
    check("s3_pulse", err_pulse, 12'h810);
    check("s3_first", {first_vld, first_fifo, first_type}, 5'b1_01_01);
    check("s3_cnt1",  err_cnt[3:2], 2'd1);
    check("s3_cnt3",  err_cnt[7:6], 2'd1);
    idle_inputs();
    step(1);
    full[1] = 1'b1; rready[1] = 1'b1;
    step(1);
    check("s3_pulse2", err_pulse, 12'h028);
    check("s3_cnt1b",  err_cnt[3:2], 2'd3);
    check("s3_first2", {first_vld, first_fifo, first_type}, 5'b1_01_01);
    idle_inputs();
    drain_alert();
    clear_all();

    // 4: counter saturation, then a clear in the same cycle as a new error.
    for (int e = 0; e < 5; e++) begin
      rready[0] = 1'b1; step(1);
      rready[0] = 1'b0; step(1);
    end
    check("s4_sat", err_cnt[1:0], 2'd3);
    rready[0] = 1'b1; clr = 1'b1;
    step(1);
    rready[0] = 1'b0; clr = 1'b0;
    check("s4_clr_cnt",    err_cnt[1:0], 2'd1);
    check("s4_clr_sticky", err_sticky,   12'h001);
    drain_alert();
    clear_all();
    step(2);

    // 5: alert handshake with an error arriving while ack is held.
    check("s5_idle", alert, 1'b0);
    rready[0] = 1'b1; step(1);
    rready[0] = 1'b0; step(1);
    check("s5_alert", alert, 1'b1);
    step(2);
    check("s5_alert_held", alert, 1'b1);
    ack = 1'b1; step(2);
    check("s5_acked", alert, 1'b0);
    rready[1] = 1'b1; step(1);
    rready[1] = 1'b0; step(3);
    check("s5_hold_no_retrig", alert, 1'b0);
    ack = 1'b0; step(2);
    check("s5_realert", alert, 1'b1);
    ack = 1'b1; step(3);
    ack = 1'b0; step(4);
    check("s5_back_idle", alert, 1'b0);
    step(3);
    check("s5_stays_idle", alert, 1'b0);

    // 6: reset in the middle of an active alert with a held condition.
    clear_all();
    step(1);
    wvalid[1] = 1'b1; full[1] = 1'b1; rready[1] = 1'b1;
    step(1);
    check("s6_pulse", err_pulse, 12'h038);
    step(2);
    check("s6_cnt1",   err_cnt[3:2], 2'd3);
    check("s6_sticky", err_sticky,   12'h038);
    check("s6_alert",  alert,        1'b1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("s6_rst_pulse",  err_pulse,  12'h000);
    check("s6_rst_sticky", err_sticky, 12'h000);
    check("s6_rst_cnt",    err_cnt,    8'h00);
    check("s6_rst_first",  first_vld,  1'b0);
    check("s6_rst_alert",  alert,      1'b0);
    step(1);
    check("s6_repulse", err_pulse, 12'h038);
    step(1);
    check("s6_repulse_once", err_pulse, 12'h000);
    idle_inputs();
    drain_alert();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wvalid = 4'($urandom & $urandom);
      wready = 4'($urandom | $urandom);
      rvalid = 4'($urandom);
      rready = 4'($urandom & $urandom);
      full   = 4'($urandom & $urandom);
      clr    = ($urandom_range(15) == 0);
      if ($urandom_range(5) == 0) ack = ~ack;
      rst_n  = ($urandom_range(199) != 0);
      step(1);
    end
    rst_n = 1'b1;
    idle_inputs();
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
